// File: rtl/wb_sequencer_pkg.sv
// Shared constants, write-port types and the destination-select helper for wb_sequencer.
package wb_sequencer_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    // Which source owns the register-file write port in a given cycle.
    typedef enum logic [1:0] {
        WB_SRC_NONE  = 2'd0,
        WB_SRC_LOAD  = 2'd1,
        WB_SRC_HOLD  = 2'd2,
        WB_SRC_ISSUE = 2'd3
    } wb_src_e;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_write_t;

    function automatic logic [4:0] sel_dest(input logic       jal,
                                            input logic       reg_dst,
                                            input logic [4:0] rt,
                                            input logic [4:0] rd);
        if (jal) return REG_RA;
        return reg_dst ? rd : rt;
    endfunction

endpackage

// File: rtl/wb_dest_fifo.sv
// Destination FIFO for in-flight loads: LD_DEPTH entries of 5-bit register numbers, issue order.
// A push and a pop in the same cycle are both honoured, including when the FIFO is full.
module wb_dest_fifo #(
    parameter int LD_DEPTH = 4,
    parameter int CNT_W    = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [4:0]       push_dest,
    input  logic             pop,
    output logic [4:0]       head_dest,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(LD_DEPTH);

    logic [4:0]       mem [LD_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CNT_W'(LD_DEPTH));
    assign empty     = (count == '0);
    assign do_pop    = pop & ~empty;
    assign do_push   = push & (~full | do_pop);
    assign head_dest = mem[rd_ptr];

    // NOTE: the storage array has no reset; pointers and count alone decide which entries are live.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_dest;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Depth is a power of two, so pointer overflow is the modulo wrap.
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_sequencer.sv
// Register write-back sequencer: one registered write port fed by load returns, a hold slot and ALU/JAL issue.
// Optional build macro WB_BYPASS_EN adds rf_w* forwarding and drops the write-port read-after-write stall.
module wb_sequencer #(
    parameter int LD_DEPTH = 4,
    parameter int CNT_W    = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             iss_valid,
    output logic             iss_stall,
    input  logic             RegWrite,
    input  logic             Jal,
    input  logic             RegDst,
    input  logic             MemtoReg,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic [4:0]       rd,
    input  logic [31:0]      ALU_result,
    input  logic [31:0]      opcplus4,
    input  logic             ld_valid,
    input  logic [31:0]      ld_data,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic [31:0]      busy_mask,
    output logic [CNT_W-1:0] pend_count,
    output logic             ld_err,
    output logic             fwd_rs_hit,
    output logic             fwd_rt_hit,
    output logic [31:0]      fwd_rs_data,
    output logic [31:0]      fwd_rt_data
);

    import wb_sequencer_pkg::*;

    logic [4:0]  dest;
    logic [4:0]  head_dest;
    logic        fifo_full;
    logic        fifo_empty;
    logic        load_ret;
    logic        hazard;
    logic        raw_stall;
    logic        accept;
    logic        issue_ld;
    logic        issue_alu;
    logic        hold_valid;
    wb_write_t   hold_wr;
    wb_write_t   issue_wr;
    wb_write_t   wb_next;
    wb_src_e     wb_src;
    logic [31:0] busy_next;

    assign dest     = sel_dest(Jal, RegDst, rt, rd);
    assign load_ret = ld_valid & ~fifo_empty;

    // busy_mask[0] is held at zero, so register 0 never contributes a hazard.
    assign hazard = busy_mask[rs] | busy_mask[rt] | busy_mask[dest];

`ifdef WB_BYPASS_EN
    assign raw_stall   = 1'b0;
    assign fwd_rs_hit  = rf_we & (rf_waddr == rs) & (rs != REG_ZERO);
    assign fwd_rt_hit  = rf_we & (rf_waddr == rt) & (rt != REG_ZERO);
    assign fwd_rs_data = rf_wdata;
    assign fwd_rt_data = rf_wdata;
`else
    // The register file is not yet updated while rf_w* is in flight, so a reader waits one cycle.
    assign raw_stall   = rf_we & (rf_waddr != REG_ZERO) & ((rf_waddr == rs) | (rf_waddr == rt));
    assign fwd_rs_hit  = 1'b0;
    assign fwd_rt_hit  = 1'b0;
    assign fwd_rs_data = '0;
    assign fwd_rt_data = '0;
`endif

    // A full FIFO still accepts a load when a return frees the head in the same cycle.
    assign iss_stall = iss_valid & (hazard
                                    | (MemtoReg & RegWrite & fifo_full & ~ld_valid)
                                    | hold_valid
                                    | raw_stall);

    assign accept        = iss_valid & ~iss_stall;
    assign issue_ld      = accept & RegWrite & MemtoReg;
    assign issue_alu     = accept & RegWrite & ~MemtoReg;
    assign issue_wr.addr = dest;
    assign issue_wr.data = Jal ? opcplus4 : ALU_result;

    wb_dest_fifo #(
        .LD_DEPTH (LD_DEPTH),
        .CNT_W    (CNT_W)
    ) u_dest_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (issue_ld),
        .push_dest (dest),
        .pop       (ld_valid),
        .head_dest (head_dest),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (pend_count)
    );

    // Write-port arbitration: load return, then the hold slot, then a fresh ALU/JAL result.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        wb_src  = WB_SRC_NONE;
        wb_next = '0;
        if (load_ret) begin
            wb_src       = WB_SRC_LOAD;
            wb_next.addr = head_dest;
            wb_next.data = ld_data;
        end else if (hold_valid) begin
            wb_src  = WB_SRC_HOLD;
            wb_next = hold_wr;
        end else if (issue_alu) begin
            wb_src  = WB_SRC_ISSUE;
            wb_next = issue_wr;
        end
    end

    always_comb begin
        busy_next = busy_mask;
        if (load_ret) busy_next[head_dest] = 1'b0;
        if (issue_ld) busy_next[dest]      = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            busy_mask  <= '0;
            hold_valid <= 1'b0;
            hold_wr    <= '0;
            ld_err     <= 1'b0;
        end else begin
            rf_we <= (wb_src != WB_SRC_NONE) && (wb_next.addr != REG_ZERO);
            if (wb_src != WB_SRC_NONE) begin
                rf_waddr <= wb_next.addr;
                rf_wdata <= wb_next.data;
            end

            busy_mask <= busy_next;

            // An ALU/JAL result that loses the port to a load return parks in the hold slot.
            if (issue_alu && load_ret) begin
                hold_valid <= 1'b1;
                hold_wr    <= issue_wr;
            end else if (wb_src == WB_SRC_HOLD) begin
                hold_valid <= 1'b0;
            end

            if (ld_valid && fifo_empty) ld_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_sequencer.sv
// Self-checking bench for wb_sequencer: vector table, directed multi-cycle sequences, random vs. queue model.
module tb_wb_sequencer;

    localparam int LD_DEPTH = 4;
    localparam int CNT_W    = 3;

`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic             iss_valid;
    logic             iss_stall;
    logic             RegWrite;
    logic             Jal;
    logic             RegDst;
    logic             MemtoReg;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [31:0]      ALU_result;
    logic [31:0]      opcplus4;
    logic             ld_valid;
    logic [31:0]      ld_data;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [31:0]      rf_wdata;
    logic [31:0]      busy_mask;
    logic [CNT_W-1:0] pend_count;
    logic             ld_err;
    logic             fwd_rs_hit;
    logic             fwd_rt_hit;
    logic [31:0]      fwd_rs_data;
    logic [31:0]      fwd_rt_data;

    int n_vec = 0;
    int n_err = 0;

    wb_sequencer #(
        .LD_DEPTH (LD_DEPTH),
        .CNT_W    (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .iss_valid   (iss_valid),
        .iss_stall   (iss_stall),
        .RegWrite    (RegWrite),
        .Jal         (Jal),
        .RegDst      (RegDst),
        .MemtoReg    (MemtoReg),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .ALU_result  (ALU_result),
        .opcplus4    (opcplus4),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .busy_mask   (busy_mask),
        .pend_count  (pend_count),
        .ld_err      (ld_err),
        .fwd_rs_hit  (fwd_rs_hit),
        .fwd_rt_hit  (fwd_rt_hit),
        .fwd_rs_data (fwd_rs_data),
        .fwd_rt_data (fwd_rt_data)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic        jal;
        logic        regdst;
        logic        regwrite;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic        exp_we;
        logic [4:0]  exp_waddr;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    // Reference model state: outstanding load destinations, parked writes, last predicted port write.
    logic [4:0]  m_ldq[$];
    wr_t         m_hold[$];
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic        m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        iss_valid  = 1'b0;
        RegWrite   = 1'b0;
        Jal        = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        rs         = '0;
        rt         = '0;
        rd         = '0;
        ALU_result = '0;
        opcplus4   = '0;
        ld_valid   = 1'b0;
        ld_data    = '0;
    endtask

    task automatic drive_issue(input logic rw, input logic jal, input logic regdst, input logic m2r,
                               input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                               input logic [31:0] alu, input logic [31:0] pc4);
        iss_valid  = 1'b1;
        RegWrite   = rw;
        Jal        = jal;
        RegDst     = regdst;
        MemtoReg   = m2r;
        rs         = s;
        rt         = t;
        rd         = d;
        ALU_result = alu;
        opcplus4   = pc4;
    endtask

    task automatic drive_load(input logic [4:0] t);
        drive_issue(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, t, 5'd0, 32'h0, 32'h0);
    endtask

    function automatic bit m_busy(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (m_ldq[i]) if (m_ldq[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_busy_mask();
        logic [31:0] m;
        m = '0;
        foreach (m_ldq[i]) if (m_ldq[i] != 5'd0) m[m_ldq[i]] = 1'b1;
        return m;
    endfunction

    task automatic run_random(input int cycles);
        logic [4:0]  m_dest;
        logic        m_stall;
        logic        m_acc;
        logic        port;
        logic        nwe;
        logic [4:0]  na;
        logic [31:0] nd;
        logic [4:0]  hd;
        wr_t         hw;
        logic        exp_rs_hit;
        logic        exp_rt_hit;
        for (int c = 0; c < cycles; c++) begin
            iss_valid  = ($urandom_range(0, 9) < 7);
            RegWrite   = ($urandom_range(0, 4) != 0);
            MemtoReg   = ($urandom_range(0, 2) == 0);
            Jal        = !MemtoReg && ($urandom_range(0, 7) == 0);
            RegDst     = $urandom_range(0, 1) != 0;
            rs         = 5'($urandom_range(0, 7));
            rt         = 5'($urandom_range(0, 7));
            rd         = 5'($urandom_range(0, 7));
            ALU_result = $urandom;
            opcplus4   = $urandom;
            ld_valid   = (m_ldq.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 19) == 0);
            ld_data    = $urandom;
            #1;

            m_dest  = Jal ? 5'd31 : (RegDst ? rd : rt);
            m_stall = iss_valid && (m_busy(rs) || m_busy(rt) || m_busy(m_dest)
                      || (MemtoReg && RegWrite && m_ldq.size() == LD_DEPTH && !ld_valid)
                      || m_hold.size() != 0
                      || (!BYPASS && m_we && (m_waddr == rs || m_waddr == rt)));
            check("rand_stall", 32'(iss_stall), 32'(m_stall));

            exp_rs_hit = BYPASS && m_we && (m_waddr == rs) && (rs != 5'd0);
            exp_rt_hit = BYPASS && m_we && (m_waddr == rt) && (rt != 5'd0);
            check("rand_fwd_rs_hit", 32'(fwd_rs_hit), 32'(exp_rs_hit));
            check("rand_fwd_rt_hit", 32'(fwd_rt_hit), 32'(exp_rt_hit));
            if (exp_rs_hit) check("rand_fwd_rs_data", fwd_rs_data, m_wdata);

            m_acc = iss_valid && !m_stall;
            port  = 1'b0;
            nwe   = 1'b0;
            na    = '0;
            nd    = '0;
            if (ld_valid) begin
                if (m_ldq.size() != 0) begin
                    hd   = m_ldq.pop_front();
                    port = 1'b1;
                    nwe  = (hd != 5'd0);
                    na   = hd;
                    nd   = ld_data;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (!port && m_hold.size() != 0) begin
                hw   = m_hold.pop_front();
                port = 1'b1;
                nwe  = (hw.a != 5'd0);
                na   = hw.a;
                nd   = hw.d;
            end
            if (m_acc && RegWrite && MemtoReg) m_ldq.push_back(m_dest);
            if (m_acc && RegWrite && !MemtoReg) begin
                if (port) begin
                    m_hold.push_back({m_dest, (Jal ? opcplus4 : ALU_result)});
                end else begin
                    nwe = (m_dest != 5'd0);
                    na  = m_dest;
                    nd  = Jal ? opcplus4 : ALU_result;
                end
            end
            m_we    = nwe;
            m_waddr = na;
            m_wdata = nd;

            tick();
            check("rand_rf_we", 32'(rf_we), 32'(m_we));
            if (m_we) begin
                check("rand_rf_waddr", 32'(rf_waddr), 32'(m_waddr));
                check("rand_rf_wdata", rf_wdata, m_wdata);
            end
            check("rand_busy_mask", busy_mask, m_busy_mask());
            check("rand_pend_count", 32'(pend_count), 32'(m_ldq.size()));
            check("rand_ld_err", 32'(ld_err), 32'(m_err));
        end
        clear_inputs();
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b1, 5'd1, 5'd2,  5'd8,  32'h0000_1234, 32'h0,         1'b1, 5'd8,  32'h0000_1234};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 5'd0, 5'd0,  5'd0,  32'hDEAD_BEEF, 32'h0040_0010, 1'b1, 5'd31, 32'h0040_0010};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 5'd3, 5'd4,  5'd0,  32'h0000_5555, 32'h0,         1'b0, 5'd0,  32'h0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 5'd1, 5'd12, 5'd20, 32'h0000_A5A5, 32'h0,         1'b1, 5'd12, 32'h0000_A5A5};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 5'd1, 5'd2,  5'd9,  32'h0000_9999, 32'h0,         1'b0, 5'd0,  32'h0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 5'd0, 5'd0,  5'd3,  32'h0000_0003, 32'h0000_1000, 1'b1, 5'd31, 32'h0000_1000};

        clear_inputs();
        reset = 1'b1;
        #1;
        check("reset_rf_we", 32'(rf_we), 32'h0);
        check("reset_rf_waddr", 32'(rf_waddr), 32'h0);
        check("reset_rf_wdata", rf_wdata, 32'h0);
        check("reset_busy_mask", busy_mask, 32'h0);
        check("reset_pend_count", 32'(pend_count), 32'h0);
        check("reset_ld_err", 32'(ld_err), 32'h0);
        check("reset_fwd_rs_hit", 32'(fwd_rs_hit), 32'h0);
        check("reset_iss_stall", 32'(iss_stall), 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        tick();

        // Single-cycle ALU/JAL writes from the vector table.
        for (int i = 0; i < 6; i++) begin
            drive_issue(vecs[i].regwrite, vecs[i].jal, vecs[i].regdst, 1'b0,
                        vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].alu, vecs[i].pc4);
            #1;
            check($sformatf("vec%0d_stall", i), 32'(iss_stall), 32'h0);
            tick();
            clear_inputs();
            check($sformatf("vec%0d_rf_we", i), 32'(rf_we), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                check($sformatf("vec%0d_rf_waddr", i), 32'(rf_waddr), 32'(vecs[i].exp_waddr));
                check($sformatf("vec%0d_rf_wdata", i), rf_wdata, vecs[i].exp_wdata);
            end
            tick();
        end

        // Load-use hazard on r5.
        drive_load(5'd5);
        tick();
        check("haz_busy_set", busy_mask, 32'h0000_0020);
        check("haz_pend1", 32'(pend_count), 32'h1);
        drive_issue(1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 5'd6, 5'd7, 32'h0000_0077, 32'h0);
        #1;
        check("haz_stall_a", 32'(iss_stall), 32'h1);
        tick();
        check("haz_stall_b", 32'(iss_stall), 32'h1);
        ld_valid = 1'b1;
        ld_data  = 32'h0000_CAFE;
        #1;
        check("haz_stall_ldret", 32'(iss_stall), 32'h1);
        tick();
        ld_valid = 1'b0;
        #1;
        check("haz_ld_we", 32'(rf_we), 32'h1);
        check("haz_ld_waddr", 32'(rf_waddr), 32'd5);
        check("haz_ld_wdata", rf_wdata, 32'h0000_CAFE);
        check("haz_busy_clr", busy_mask, 32'h0);
        check("haz_pend0", 32'(pend_count), 32'h0);
`ifdef WB_BYPASS_EN
        check("byp_stall", 32'(iss_stall), 32'h0);
        check("byp_rs_hit", 32'(fwd_rs_hit), 32'h1);
        check("byp_rs_data", fwd_rs_data, 32'h0000_CAFE);
        check("byp_rt_hit", 32'(fwd_rt_hit), 32'h0);
`else
        check("raw_stall", 32'(iss_stall), 32'h1);
        check("raw_no_fwd", 32'(fwd_rs_hit), 32'h0);
        tick();
        check("raw_stall_gone", 32'(iss_stall), 32'h0);
`endif
        tick();
        clear_inputs();
        check("haz_alu_we", 32'(rf_we), 32'h1);
        check("haz_alu_waddr", 32'(rf_waddr), 32'd7);
        check("haz_alu_wdata", rf_wdata, 32'h0000_0077);
        tick();

        // ALU write colliding with a load return goes through the hold slot.
        drive_load(5'd4);
        tick();
        drive_issue(1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd9, 32'h0000_0099, 32'h0);
        ld_valid = 1'b1;
        ld_data  = 32'h0000_0044;
        #1;
        check("col_accept", 32'(iss_stall), 32'h0);
        tick();
        ld_valid = 1'b0;
        drive_issue(1'b0, 1'b0, 1'b1, 1'b0, 5'd10, 5'd11, 5'd12, 32'h0, 32'h0);
        #1;
        check("col_c1_waddr", 32'(rf_waddr), 32'd4);
        check("col_c1_wdata", rf_wdata, 32'h0000_0044);
        check("col_hold_stall", 32'(iss_stall), 32'h1);
        tick();
        check("col_c2_we", 32'(rf_we), 32'h1);
        check("col_c2_waddr", 32'(rf_waddr), 32'd9);
        check("col_c2_wdata", rf_wdata, 32'h0000_0099);
        check("col_hold_free", 32'(iss_stall), 32'h0);
        clear_inputs();
        tick();

        // Fill the FIFO, push+pop while full, drain, then an unmatched return.
        for (int i = 1; i <= LD_DEPTH; i++) begin
            drive_load(5'(i));
            #1;
            check($sformatf("fifo_push%0d_stall", i), 32'(iss_stall), 32'h0);
            tick();
        end
        check("fifo_full_count", 32'(pend_count), 32'd4);
        check("fifo_full_busy", busy_mask, 32'h0000_001E);
        drive_load(5'd6);
        #1;
        check("fifo_full_stall", 32'(iss_stall), 32'h1);
        tick();
        check("fifo_full_hold_count", 32'(pend_count), 32'd4);
        ld_valid = 1'b1;
        ld_data  = 32'h0000_0011;
        #1;
        check("fifo_pushpop_accept", 32'(iss_stall), 32'h0);
        tick();
        iss_valid = 1'b0;
        check("fifo_pp_waddr", 32'(rf_waddr), 32'd1);
        check("fifo_pp_wdata", rf_wdata, 32'h0000_0011);
        check("fifo_pp_count", 32'(pend_count), 32'd4);
        check("fifo_pp_busy", busy_mask, 32'h0000_005C);
        begin
            logic [4:0] order [4];
            order = '{5'd2, 5'd3, 5'd4, 5'd6};
            for (int k = 0; k < 4; k++) begin
                ld_data = 32'h0000_0020 + 32'(k);
                tick();
                check($sformatf("drain%0d_we", k), 32'(rf_we), 32'h1);
                check($sformatf("drain%0d_waddr", k), 32'(rf_waddr), 32'(order[k]));
                check($sformatf("drain%0d_wdata", k), rf_wdata, 32'h0000_0020 + 32'(k));
            end
        end
        check("drain_count", 32'(pend_count), 32'h0);
        check("drain_busy", busy_mask, 32'h0);
        ld_data = 32'h0000_0BAD;
        tick();
        ld_valid = 1'b0;
        check("empty_ret_no_we", 32'(rf_we), 32'h0);
        check("empty_ret_err", 32'(ld_err), 32'h1);
        tick();
        check("err_sticky", 32'(ld_err), 32'h1);

        // Load to r0: popped without a write.
        drive_load(5'd0);
        tick();
        clear_inputs();
        check("r0_load_count", 32'(pend_count), 32'h1);
        check("r0_load_busy", busy_mask, 32'h0);
        ld_valid = 1'b1;
        ld_data  = 32'h0000_0777;
        tick();
        ld_valid = 1'b0;
        check("r0_load_no_we", 32'(rf_we), 32'h0);
        check("r0_load_popped", 32'(pend_count), 32'h0);

        // Reset with a load outstanding.
        drive_load(5'd3);
        tick();
        clear_inputs();
        check("midrst_pend", 32'(pend_count), 32'h1);
        reset = 1'b1;
        #1;
        check("midrst_count", 32'(pend_count), 32'h0);
        check("midrst_busy", busy_mask, 32'h0);
        check("midrst_err", 32'(ld_err), 32'h0);
        tick();
        reset    = 1'b0;
        ld_valid = 1'b1;
        ld_data  = 32'h0000_0033;
        tick();
        ld_valid = 1'b0;
        check("midrst_ret_err", 32'(ld_err), 32'h1);
        check("midrst_ret_no_we", 32'(rf_we), 32'h0);

        // Randomized traffic against the queue model.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_ldq.delete();
        m_hold.delete();
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        m_err   = 1'b0;
        run_random(400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
